// File: rtl/fm_pkg.sv
// Shared constants, CORDIC arctangent table and FSM state type for the FM modulator.
// All angles are Q.10 radians (1.0 = 1024).
package fm_pkg;

    localparam int Q_FRAC     = 10;
    localparam int PI_Q       = 3217;
    localparam int HALF_PI_Q  = 1608;
    localparam int TWO_PI_Q   = 6434;
    localparam int CORDIC_K_Q = 622;

    localparam int ATAN_Q [16] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0, 0};

    typedef enum logic [2:0] {
        IDLE,
        SCALE,
        WRAP,
        ROTATE,
        DONE
    } fm_mod_state_t;

endpackage

// File: rtl/fm_modulator_cordic.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle, done pulses ITER+1 cycles
// after start. The vector carries guard bits so shift truncation stays well under 1 LSB.
module cordic_rotate
    import fm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITER       = 10,
    parameter int AMP        = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] angle,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] cos_o,
    output logic signed [DATA_WIDTH-1:0] sin_o
);

    localparam int GUARD = 6;
    localparam int W     = DATA_WIDTH + GUARD;
    localparam int X0    = (AMP * CORDIC_K_Q) / 1024;
    localparam logic signed [W-1:0] X_INIT = W'(X0 * (2 ** GUARD));
    localparam logic signed [W-1:0] RND    = W'(2 ** (GUARD - 1));
    localparam logic [4:0]          LAST   = 5'(ITER);

    logic signed [W-1:0]          xr, yr;
    logic signed [DATA_WIDTH-1:0] zr, atan_v;
    logic [4:0]                   idx;
    logic                         busy, done_r;

    assign atan_v = DATA_WIDTH'(ATAN_Q[idx[3:0]]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                xr   <= X_INIT;
                yr   <= '0;
                zr   <= angle;
                idx  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (idx == LAST) begin
                    busy   <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    if (zr >= 0) begin
                        xr <= xr - (yr >>> idx);
                        yr <= yr + (xr >>> idx);
                        zr <= zr - atan_v;
                    end else begin
                        xr <= xr + (yr >>> idx);
                        yr <= yr - (xr >>> idx);
                        zr <= zr + atan_v;
                    end
                    idx <= idx + 5'd1;
                end
            end
        end
    end

    assign done  = done_r;
    assign cos_o = DATA_WIDTH'((xr + RND) >>> GUARD);
    assign sin_o = DATA_WIDTH'((yr + RND) >>> GUARD);

endmodule

// File: rtl/fm_modulator.sv
// FM modulator: audio*gain phase increment into a wrapped accumulator, quadrant fold,
// CORDIC rotation to AMP*cos/sin, registered I/Q outputs.
module fm_modulator
    import fm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITER       = 10,
    parameter int AMP        = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] audio,
    input  logic signed [DATA_WIDTH-1:0] gain,
    output logic                         ready,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] PI_W     = DATA_WIDTH'(PI_Q);
    localparam logic signed [DATA_WIDTH-1:0] HALF_W   = DATA_WIDTH'(HALF_PI_Q);
    localparam logic signed [DATA_WIDTH-1:0] TWO_PI_W = DATA_WIDTH'(TWO_PI_Q);
    localparam logic signed [W2-1:0]         Q_ONE    = W2'(2 ** Q_FRAC);

    fm_mod_state_t state, state_next;

    logic signed [DATA_WIDTH-1:0] audio_r, gain_r, phase, angle, delta, cos_v, sin_v;
    logic signed [W2-1:0]         product;
    logic                         neg, neg_next, in_range, cordic_start, cordic_done;

    assign product  = W2'(gain_r) * W2'(audio_r);
    assign delta    = DATA_WIDTH'(product / Q_ONE);
    assign in_range = (phase < PI_W) && (phase >= -PI_W);

    // Fold outer quadrants into [-pi/2, pi/2] so the CORDIC stays inside its convergence range.
    always_comb begin
        angle    = phase;
        neg_next = 1'b0;
        if (phase > HALF_W) begin
            angle    = phase - PI_W;
            neg_next = 1'b1;
        end else if (phase < -HALF_W) begin
            angle    = phase + PI_W;
            neg_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        cordic_start = 1'b0;
        case (state)
            IDLE:   if (start) state_next = SCALE;
            SCALE:  state_next = WRAP;
            WRAP: begin
                if (in_range) begin
                    cordic_start = 1'b1;
                    state_next   = ROTATE;
                end
            end
            ROTATE: if (cordic_done) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            audio_r <= '0;
            gain_r  <= '0;
            phase   <= '0;
            neg     <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        audio_r <= audio;
                        gain_r  <= gain;
                    end
                end
                SCALE: phase <= phase + delta;
                WRAP: begin
                    if (phase >= PI_W)       phase <= phase - TWO_PI_W;
                    else if (phase < -PI_W)  phase <= phase + TWO_PI_W;
                    else                     neg   <= neg_next;
                end
                ROTATE: begin
                    if (cordic_done) begin
                        x <= neg ? -cos_v : cos_v;
                        y <= neg ? -sin_v : sin_v;
                    end
                end
                default: ;
            endcase
        end
    end

    cordic_rotate #(
        .DATA_WIDTH (DATA_WIDTH),
        .ITER       (ITER),
        .AMP        (AMP)
    ) u_cordic (
        .clock (clock),
        .reset (reset),
        .start (cordic_start),
        .angle (angle),
        .done  (cordic_done),
        .cos_o (cos_v),
        .sin_o (sin_v)
    );

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_fm_modulator.sv
// Bench for fm_modulator: directed cases plus random samples against a real-arithmetic
// phase/cos/sin reference model.
module tb_fm_modulator;

    localparam int ITER = 10;
    localparam int TOL  = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [31:0] audio = '0;
    logic signed [31:0] gain  = '0;
    logic               ready, done;
    logic signed [31:0] x, y;

    int vectors     = 0;
    int miscompares = 0;
    int phase_m     = 0;

    fm_modulator #(.DATA_WIDTH(32), .ITER(ITER), .AMP(1024)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .audio (audio),
        .gain  (gain),
        .ready (ready),
        .done  (done),
        .x     (x),
        .y     (y)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint exp);
        vectors++;
        assert ((obs - exp <= TOL) && (exp - obs <= TOL)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
        end
    endtask

    function automatic int round_real(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        phase_m = 0;
    endtask

    // One sample through the DUT: model the phase, then check latency, pulse width and I/Q.
    task automatic run(input int a, input int g, input bit hold, input string tag);
        longint p;
        int     corr, n, ex, ey;
        bit     seen, busy_ready;
        p       = longint'(g) * longint'(a);
        phase_m = int'(longint'(phase_m) + p / 1024);
        corr    = 0;
        while (phase_m >= 3217) begin phase_m -= 6434; corr++; end
        while (phase_m < -3217) begin phase_m += 6434; corr++; end
        ex = round_real(1024.0 * $cos(real'(phase_m) / 1024.0));
        ey = round_real(1024.0 * $sin(real'(phase_m) / 1024.0));

        chk({tag, "_ready_idle"}, ready, 1);
        audio = a;
        gain  = g;
        start = 1'b1;
        @(posedge clock);
        #1 if (!hold) start = 1'b0;
        n = 0; seen = 1'b0; busy_ready = 1'b0;
        while (!seen && n < 80) begin
            if (ready) busy_ready = 1'b1;
            @(posedge clock);
            #1 n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_ready_busy"}, busy_ready, 0);
        if (seen) begin
            chk({tag, "_latency"}, n, ITER + 4 + corr);
            chk_near({tag, "_x"}, x, ex);
            chk_near({tag, "_y"}, y, ey);
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_ready_after"}, ready, 1);
    endtask

    initial begin
        int ok_idle;
        bit got_done;

        // 1: reset, idle
        do_reset();
        repeat (5) @(posedge clock);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 1);

        // 2: zero audio, phase stays 0
        run(0, 1024, 1'b0, "zero");
        run(0, 1024, 1'b0, "zero2");

        // 3: pi/4 then 3pi/4
        do_reset();
        run(804, 1024, 1'b0, "pi4");
        run(1608, 1024, 1'b0, "pi34");

        // 4: positive wrap on second sample
        do_reset();
        run(3000, 1024, 1'b0, "wrap_a");
        run(3000, 1024, 1'b0, "wrap_b");

        // 5: negative wrap
        do_reset();
        run(3300, -1024, 1'b0, "negwrap");

        // 6: start held through an operation, not queued afterwards
        do_reset();
        run(500, 1024, 1'b1, "hold");
        ok_idle = 1;
        repeat (3) begin
            @(posedge clock);
            #1 if (!ready || done) ok_idle = 0;
        end
        chk("hold_no_requeue", ok_idle, 1);

        // reset in ROTATE aborts without done and clears phase
        audio = 1000; gain = 1024; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (ITER / 2 + 3) @(posedge clock);
        #1 reset = 1'b1;
        phase_m = 0;
        got_done = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1 if (done) got_done = 1'b1;
        end
        reset = 1'b0;
        repeat (30) begin
            @(posedge clock);
            #1 if (done) got_done = 1'b1;
        end
        chk("abort_no_done", got_done, 0);
        chk("abort_x_cleared", x, 0);
        run(0, 1024, 1'b0, "post_abort");

        // random samples
        do_reset();
        for (int i = 0; i < 20; i++) begin
            int a, g;
            a = int'($urandom_range(8000, 0)) - 4000;
            g = int'($urandom_range(2048, 0)) - 1024;
            run(a, g, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
